// File: rtl/bram_to_video_pkg.sv
// Shared types and helpers for the BRAM line replay block.
package bram_to_video_pkg;

  // Replay sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FSYNC = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BLANK = 3'd4
  } rd_state_t;

  // Supported BRAM read latencies
  localparam int NB_MIN_RD_LATENCY = 1;
  localparam int NB_MAX_RD_LATENCY = 2;

  // True when the line length fits the address space and the latency is supported
  function automatic bit params_ok(input int nb_pixels, input int wd_addr, input int nb_latency);
    longint depth;
    depth = longint'(1) << wd_addr;
    return (nb_pixels >= 1) && (longint'(nb_pixels) <= depth) &&
           (nb_latency >= NB_MIN_RD_LATENCY) && (nb_latency <= NB_MAX_RD_LATENCY);
  endfunction

endpackage

// File: rtl/bram_to_video_if.sv
// BRAM read port and sensor-style video output bundled as one interface.
interface bram_to_video_if #(
  parameter int WD_BRAM_ADDR  = 9,
  parameter int WD_BRAM_DATA  = 8,
  parameter int WD_VIDEO_DATA = 8
);

  logic [WD_BRAM_ADDR-1:0]  m_bram_src_addr;
  logic                     m_bram_src_clk;
  logic [WD_BRAM_DATA-1:0]  m_bram_src_din;
  logic [WD_BRAM_DATA-1:0]  m_bram_src_dout;
  logic                     m_bram_src_en;
  logic                     m_bram_src_rst;
  logic                     m_bram_src_we;

  logic                     m_video_dst_fsync;
  logic                     m_video_dst_vsync;
  logic                     m_video_dst_hsync;
  logic                     m_video_dst_psync;
  logic [WD_VIDEO_DATA-1:0] m_video_dst_vdata;

  // Replay block side: drives the BRAM port and the video stream
  modport master (
    output m_bram_src_addr, m_bram_src_clk, m_bram_src_din, m_bram_src_en,
           m_bram_src_rst, m_bram_src_we,
    input  m_bram_src_dout,
    output m_video_dst_fsync, m_video_dst_vsync, m_video_dst_hsync,
           m_video_dst_psync, m_video_dst_vdata
  );

  // BRAM / video sink side
  modport slave (
    input  m_bram_src_addr, m_bram_src_clk, m_bram_src_din, m_bram_src_en,
           m_bram_src_rst, m_bram_src_we,
    output m_bram_src_dout,
    input  m_video_dst_fsync, m_video_dst_vsync, m_video_dst_hsync,
           m_video_dst_psync, m_video_dst_vdata
  );

endinterface

// File: rtl/bram_to_video_rd_align.sv
// Aligns pixel flags with BRAM read data and registers the video outputs.
module bram_rd_align
  import bram_to_video_pkg::*;
#(
  parameter int NB_RD_LATENCY = 1,
  parameter int WD_BRAM_DATA  = 8,
  parameter int WD_VIDEO_DATA = 8
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  input  logic                     en,
  input  logic                     first,
  input  logic                     last,
  input  logic [WD_BRAM_DATA-1:0]  dout,
  output logic                     psync,
  output logic                     hsync,
  output logic                     vsync,
  output logic [WD_VIDEO_DATA-1:0] vdata,
  output logic                     rd_last
);

  // Out-of-range latencies are clamped so the pipe stays legal; the top flags them
  localparam int LAT = (NB_RD_LATENCY > NB_MAX_RD_LATENCY) ? NB_MAX_RD_LATENCY :
                       (NB_RD_LATENCY < NB_MIN_RD_LATENCY) ? NB_MIN_RD_LATENCY :
                       NB_RD_LATENCY;

  logic [LAT-1:0]           valid_pipe;
  logic [LAT-1:0]           first_pipe;
  logic [LAT-1:0]           last_pipe;
  logic                     last_out;
  logic [WD_VIDEO_DATA-1:0] pixel;

  // Low BRAM bits when the pixel is narrower, zero-extension when it is wider
  generate
    if (WD_VIDEO_DATA <= WD_BRAM_DATA) begin : g_trunc
      assign pixel = dout[WD_VIDEO_DATA-1:0];
    end else begin : g_ext
      assign pixel = {{(WD_VIDEO_DATA-WD_BRAM_DATA){1'b0}}, dout};
    end
  endgenerate

  // Flag shift pipe matching the BRAM latency, then the output register
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      valid_pipe <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      psync      <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      vdata      <= '0;
      last_out   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      valid_pipe[0] <= en;
      first_pipe[0] <= first;
      last_pipe[0]  <= last;
      for (int i = 1; i < LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
      psync    <= valid_pipe[LAT-1];
      vsync    <= valid_pipe[LAT-1];
      hsync    <= first_pipe[LAT-1];
      last_out <= last_pipe[LAT-1];
      rd_last  <= last_out;
      if (valid_pipe[LAT-1]) begin
        vdata <= pixel;
      end
    end
  end

endmodule

// File: rtl/bram_to_video.sv
// Replays one stored BRAM line as a sensor-style fsync/vsync/hsync/psync stream.
module bram_to_video
  import bram_to_video_pkg::*;
#(
  parameter int MD_SIM_ABLE    = 0,
  parameter int WD_BRAM_ADDR   = 9,
  parameter int WD_BRAM_DATA   = 8,
  parameter int WD_VIDEO_DATA  = 8,
  parameter int WD_ERR_INFO    = 4,
  parameter int NB_LINE_PIXELS = 320,
  parameter int NB_RD_LATENCY  = 1,
  parameter int NB_HBLANK      = 16
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_info_rd_start,
  bram_to_video_if.master        bus,
  output logic                   m_info_rd_last,
  output logic [WD_ERR_INFO-1:0] m_err_video_info1
);

  localparam logic [WD_BRAM_ADDR-1:0] LAST_ADDR = WD_BRAM_ADDR'(NB_LINE_PIXELS - 1);
  localparam int                      WD_CNT    = $clog2(NB_HBLANK + NB_RD_LATENCY + 2);
  localparam logic [WD_CNT-1:0]       DRAIN_END = WD_CNT'(NB_RD_LATENCY);
  localparam logic [WD_CNT-1:0]       BLANK_END = WD_CNT'(NB_HBLANK - 1);

  rd_state_t               state;
  logic                    r_start;
  logic                    start_edge;
  logic [WD_CNT-1:0]       cnt;
  logic [WD_BRAM_ADDR-1:0] addr;
  logic                    en;
  logic                    fsync;
  logic                    bram_rst;
  logic [WD_ERR_INFO-1:0]  err;
  logic                    first_flag;
  logic                    last_flag;

  assign start_edge = s_info_rd_start & ~r_start;
  assign first_flag = en & (addr == '0);
  assign last_flag  = en & (addr == LAST_ADDR);

  assign bus.m_bram_src_clk    = i_sys_clk;
  assign bus.m_bram_src_din    = '0;
  assign bus.m_bram_src_we     = 1'b0;
  assign bus.m_bram_src_en     = en;
  assign bus.m_bram_src_addr   = addr;
  assign bus.m_bram_src_rst    = bram_rst;
  assign bus.m_video_dst_fsync = fsync;
  assign m_err_video_info1     = err;

  // Replay sequencer: start detect, address walk, drain, blanking and dropped-start count
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state    <= ST_IDLE;
      r_start  <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      en       <= 1'b0;
      fsync    <= 1'b0;
      bram_rst <= 1'b1;
      err      <= '0;
    end else begin
      r_start  <= s_info_rd_start;
      bram_rst <= 1'b0;
      fsync    <= 1'b0;
      if (start_edge && (state != ST_IDLE) && (err != '1)) begin
        err <= err + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state <= ST_FSYNC;
            fsync <= 1'b1;
          end
        end
        ST_FSYNC: begin
          state <= ST_READ;
          en    <= 1'b1;
          addr  <= '0;
        end
        ST_READ: begin
          if (addr == LAST_ADDR) begin
            state <= ST_DRAIN;
            en    <= 1'b0;
            cnt   <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_END) begin
            state <= ST_BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_END) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Simulation-only parameter and address bounds checks
  always_ff @(posedge i_sys_clk) begin
    if ((MD_SIM_ABLE != 0) && !i_sys_rst) begin
      assert (params_ok(NB_LINE_PIXELS, WD_BRAM_ADDR, NB_RD_LATENCY))
        else $error("bram_to_video: NB_LINE_PIXELS or NB_RD_LATENCY out of range");
      assert (!en || (addr <= LAST_ADDR))
        else $error("bram_to_video: read address beyond line end");
    end
  end

  bram_rd_align #(
    .NB_RD_LATENCY (NB_RD_LATENCY),
    .WD_BRAM_DATA  (WD_BRAM_DATA),
    .WD_VIDEO_DATA (WD_VIDEO_DATA)
  ) u_align (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .en        (en),
    .first     (first_flag),
    .last      (last_flag),
    .dout      (bus.m_bram_src_dout),
    .psync     (bus.m_video_dst_psync),
    .hsync     (bus.m_video_dst_hsync),
    .vsync     (bus.m_video_dst_vsync),
    .vdata     (bus.m_video_dst_vdata),
    .rd_last   (m_info_rd_last)
  );

endmodule

// File: tb/tb_bram_to_video.sv
// Directed bench: 8-pixel lines at latency 1 and 2, plus a full 512-pixel line.
module tb_bram_to_video;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_ab;
  logic       start_c;
  logic       rd_last_a, rd_last_b, rd_last_c;
  logic [3:0] err_a, err_b, err_c;
  int         cyc = 0;
  int         n_vectors = 0;
  int         n_miscompares = 0;

  logic [7:0] mem [512];
  logic [7:0] a_d1, b_d1, b_d2, c_d1;

  bram_to_video_if #(.WD_BRAM_ADDR(9), .WD_BRAM_DATA(8), .WD_VIDEO_DATA(8)) if_a ();
  bram_to_video_if #(.WD_BRAM_ADDR(9), .WD_BRAM_DATA(8), .WD_VIDEO_DATA(8)) if_b ();
  bram_to_video_if #(.WD_BRAM_ADDR(9), .WD_BRAM_DATA(8), .WD_VIDEO_DATA(8)) if_c ();

  bram_to_video #(.MD_SIM_ABLE(1), .NB_LINE_PIXELS(8), .NB_RD_LATENCY(1), .NB_HBLANK(16)) dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .s_info_rd_start(start_ab), .bus(if_a),
    .m_info_rd_last(rd_last_a), .m_err_video_info1(err_a));

  bram_to_video #(.MD_SIM_ABLE(1), .NB_LINE_PIXELS(8), .NB_RD_LATENCY(2), .NB_HBLANK(16)) dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .s_info_rd_start(start_ab), .bus(if_b),
    .m_info_rd_last(rd_last_b), .m_err_video_info1(err_b));

  bram_to_video #(.MD_SIM_ABLE(1), .NB_LINE_PIXELS(512), .NB_RD_LATENCY(1), .NB_HBLANK(16)) dut_c (
    .i_sys_clk(clk), .i_sys_rst(rst), .s_info_rd_start(start_c), .bus(if_c),
    .m_info_rd_last(rd_last_c), .m_err_video_info1(err_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 8'(k + 16);
  end

  // BRAM models with one- and two-cycle read latency
  always @(posedge clk) begin
    if (if_a.m_bram_src_en) a_d1 <= mem[if_a.m_bram_src_addr];
    if (if_b.m_bram_src_en) b_d1 <= mem[if_b.m_bram_src_addr];
    b_d2 <= b_d1;
    if (if_c.m_bram_src_en) c_d1 <= mem[if_c.m_bram_src_addr];
  end

  assign if_a.m_bram_src_dout = a_d1;
  assign if_b.m_bram_src_dout = b_d2;
  assign if_c.m_bram_src_dout = c_d1;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst_v, input logic start_ab_v, input logic start_c_v);
    rst      = rst_v;
    start_ab = start_ab_v;
    start_c  = start_c_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitRel(input int base, input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  // One 8-pixel line on dut_a (L=1) and dut_b (L=2), start edge at cycle 10
  task automatic checkLine(input int base, input int extra);
    for (int c = 10; c <= 24; c++) begin
      waitRel(base, c);
      applyStimulus(1'b0, (c == 10) || (c == extra), 1'b0);
      if (c >= 11) begin
        checkOutput($sformatf("fsync_a@%0d", c), if_a.m_video_dst_fsync, 32'(c == 11));
        checkOutput($sformatf("fsync_b@%0d", c), if_b.m_video_dst_fsync, 32'(c == 11));
        checkOutput($sformatf("en_a@%0d", c), if_a.m_bram_src_en, 32'(c >= 12 && c <= 19));
        checkOutput($sformatf("en_b@%0d", c), if_b.m_bram_src_en, 32'(c >= 12 && c <= 19));
        if (c >= 12 && c <= 19) begin
          checkOutput($sformatf("addr_a@%0d", c), if_a.m_bram_src_addr, 32'(c - 12));
          checkOutput($sformatf("addr_b@%0d", c), if_b.m_bram_src_addr, 32'(c - 12));
        end
        checkOutput($sformatf("psync_a@%0d", c), if_a.m_video_dst_psync, 32'(c >= 14 && c <= 21));
        checkOutput($sformatf("vsync_a@%0d", c), if_a.m_video_dst_vsync, 32'(c >= 14 && c <= 21));
        checkOutput($sformatf("hsync_a@%0d", c), if_a.m_video_dst_hsync, 32'(c == 14));
        checkOutput($sformatf("rd_last_a@%0d", c), rd_last_a, 32'(c == 22));
        if (c >= 14) begin
          checkOutput($sformatf("vdata_a@%0d", c), if_a.m_video_dst_vdata, (c <= 21) ? 32'(c + 2) : 32'h17);
        end
        checkOutput($sformatf("psync_b@%0d", c), if_b.m_video_dst_psync, 32'(c >= 15 && c <= 22));
        checkOutput($sformatf("vsync_b@%0d", c), if_b.m_video_dst_vsync, 32'(c >= 15 && c <= 22));
        checkOutput($sformatf("hsync_b@%0d", c), if_b.m_video_dst_hsync, 32'(c == 15));
        checkOutput($sformatf("rd_last_b@%0d", c), rd_last_b, 32'(c == 23));
        if (c >= 15) begin
          checkOutput($sformatf("vdata_b@%0d", c), if_b.m_video_dst_vdata, (c <= 22) ? 32'(c + 1) : 32'h17);
        end
      end
    end
  endtask

  // Line start at cycle 10 followed by n extra start edges while busy
  task automatic busyLine(input int n);
    int base;
    base = cyc;
    for (int c = 10; c <= 45; c++) begin
      waitRel(base, c);
      applyStimulus(1'b0, (c == 10) || (c >= 13 && c < 13 + 2 * n && ((c - 13) % 2) == 0), 1'b0);
    end
  endtask

  initial begin
    int base;
    int np_a, np_b, nf_a, nf_b, nl_a, nl_b, np_c, nl_c;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_fsync", if_a.m_video_dst_fsync, 32'd0);
    checkOutput("rst_vsync", if_a.m_video_dst_vsync, 32'd0);
    checkOutput("rst_hsync", if_a.m_video_dst_hsync, 32'd0);
    checkOutput("rst_psync", if_a.m_video_dst_psync, 32'd0);
    checkOutput("rst_vdata", if_a.m_video_dst_vdata, 32'd0);
    checkOutput("rst_en", if_a.m_bram_src_en, 32'd0);
    checkOutput("rst_addr", if_a.m_bram_src_addr, 32'd0);
    checkOutput("rst_rd_last", rd_last_a, 32'd0);
    checkOutput("rst_err", err_a, 32'd0);
    checkOutput("rst_bram_rst", if_a.m_bram_src_rst, 32'd1);
    checkOutput("rst_bram_rst_c", if_c.m_bram_src_rst, 32'd1);
    checkOutput("din_zero", if_a.m_bram_src_din, 32'd0);
    checkOutput("we_zero", if_a.m_bram_src_we, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bram_rst_released", if_a.m_bram_src_rst, 32'd0);

    // Basic line, latency 1 and 2 side by side
    $display("[TB] line replay, L=1 and L=2");
    base = cyc;
    checkLine(base, -1);
    waitRel(base, 45);
    checkOutput("err_a_idle", err_a, 32'd0);
    checkOutput("err_b_idle", err_b, 32'd0);

    // Starts during READ and in the last BLANK cycle are dropped and counted
    $display("[TB] busy starts");
    base = cyc;
    checkLine(base, 14);
    waitRel(base, 37);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRel(base, 38);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("no_fsync_a@38", if_a.m_video_dst_fsync, 32'd0);
    waitRel(base, 39);
    checkOutput("no_fsync_a@39", if_a.m_video_dst_fsync, 32'd0);
    checkOutput("no_fsync_b@39", if_b.m_video_dst_fsync, 32'd0);
    waitRel(base, 45);
    checkOutput("no_en_a@45", if_a.m_bram_src_en, 32'd0);
    checkOutput("no_en_b@45", if_b.m_bram_src_en, 32'd0);
    checkOutput("err_a_two", err_a, 32'd2);
    checkOutput("err_b_two", err_b, 32'd2);
    busyLine(12);
    checkOutput("err_a_14", err_a, 32'd14);
    checkOutput("err_b_14", err_b, 32'd14);
    busyLine(8);
    checkOutput("err_a_sat", err_a, 32'hF);
    checkOutput("err_b_sat", err_b, 32'hF);

    // Reset during pixel 3 aborts the line
    $display("[TB] mid-line reset");
    base = cyc;
    waitRel(base, 10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitRel(base, 11);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitRel(base, 17);
    checkOutput("pix3_psync_a", if_a.m_video_dst_psync, 32'd1);
    checkOutput("pix3_vdata_a", if_a.m_video_dst_vdata, 32'h13);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitRel(base, 18);
    checkOutput("abort_fsync_a", if_a.m_video_dst_fsync, 32'd0);
    checkOutput("abort_vsync_a", if_a.m_video_dst_vsync, 32'd0);
    checkOutput("abort_hsync_a", if_a.m_video_dst_hsync, 32'd0);
    checkOutput("abort_psync_a", if_a.m_video_dst_psync, 32'd0);
    checkOutput("abort_vdata_a", if_a.m_video_dst_vdata, 32'd0);
    checkOutput("abort_en_a", if_a.m_bram_src_en, 32'd0);
    checkOutput("abort_addr_a", if_a.m_bram_src_addr, 32'd0);
    checkOutput("abort_rd_last_a", rd_last_a, 32'd0);
    checkOutput("abort_bram_rst_a", if_a.m_bram_src_rst, 32'd1);
    checkOutput("abort_err_a", err_a, 32'd0);
    checkOutput("abort_psync_b", if_b.m_video_dst_psync, 32'd0);
    checkOutput("abort_vdata_b", if_b.m_video_dst_vdata, 32'd0);
    checkOutput("abort_err_b", err_b, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 19; c <= 40; c++) begin
      waitRel(base, c);
      checkOutput($sformatf("post_rst_rd_last_a@%0d", c), rd_last_a, 32'd0);
      checkOutput($sformatf("post_rst_rd_last_b@%0d", c), rd_last_b, 32'd0);
      checkOutput($sformatf("post_rst_psync_a@%0d", c), if_a.m_video_dst_psync, 32'd0);
    end
    base = cyc;
    checkLine(base, -1);
    waitRel(base, 45);
    checkOutput("err_a_after_replay", err_a, 32'd0);

    // Start level held high for 100 cycles gives exactly one line
    $display("[TB] held start");
    base = cyc;
    np_a = 0; np_b = 0; nf_a = 0; nf_b = 0; nl_a = 0; nl_b = 0;
    for (int c = 10; c <= 150; c++) begin
      waitRel(base, c);
      applyStimulus(1'b0, (c < 110), 1'b0);
      np_a += int'(if_a.m_video_dst_psync);
      np_b += int'(if_b.m_video_dst_psync);
      nf_a += int'(if_a.m_video_dst_fsync);
      nf_b += int'(if_b.m_video_dst_fsync);
      nl_a += int'(rd_last_a);
      nl_b += int'(rd_last_b);
    end
    checkOutput("held_psyncs_a", np_a, 32'd8);
    checkOutput("held_psyncs_b", np_b, 32'd8);
    checkOutput("held_fsyncs_a", nf_a, 32'd1);
    checkOutput("held_fsyncs_b", nf_b, 32'd1);
    checkOutput("held_rd_last_a", nl_a, 32'd1);
    checkOutput("held_rd_last_b", nl_b, 32'd1);
    checkOutput("held_err_a", err_a, 32'd0);
    checkOutput("held_err_b", err_b, 32'd0);

    // Full 512-pixel line uses the whole address space without wrapping
    $display("[TB] full-depth line");
    base = cyc;
    np_c = 0; nl_c = 0;
    for (int c = 10; c <= 540; c++) begin
      waitRel(base, c);
      applyStimulus(1'b0, 1'b0, (c == 10));
      if (c == 11 || c == 12) begin
        checkOutput($sformatf("fsync_c@%0d", c), if_c.m_video_dst_fsync, 32'(c == 11));
      end
      if (c >= 12 && c <= 524) begin
        checkOutput($sformatf("en_c@%0d", c), if_c.m_bram_src_en, 32'(c <= 523));
        checkOutput($sformatf("addr_c@%0d", c), if_c.m_bram_src_addr, (c <= 523) ? 32'(c - 12) : 32'd511);
      end
      if (c >= 11) begin
        checkOutput($sformatf("psync_c@%0d", c), if_c.m_video_dst_psync, 32'(c >= 14 && c <= 525));
      end
      if (c >= 14 && c <= 525) begin
        checkOutput($sformatf("vdata_c@%0d", c), if_c.m_video_dst_vdata, 32'((c + 2) & 8'hFF));
      end
      if (c == 526) begin
        checkOutput("rd_last_c@526", rd_last_c, 32'd1);
      end
      np_c += int'(if_c.m_video_dst_psync);
      nl_c += int'(rd_last_c);
    end
    checkOutput("full_psyncs_c", np_c, 32'd512);
    checkOutput("full_rd_last_c", nl_c, 32'd1);
    checkOutput("full_err_c", err_c, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
